// File: rtl/attendant_button_conditioner_pkg.sv
// Shared button-bus definitions for the attendant call front end and its consumer FSM.
// Bus bit positions are fixed here so both sides index the 2-bit bus identically.
package attendant_button_conditioner_pkg;

   localparam int BTN_W               = 2;
   localparam int CALL_IDX            = 1;
   localparam int CANCEL_IDX          = 0;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef logic [BTN_W-1:0] btn_t;

   function automatic int cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/attendant_button_conditioner_if.sv
// Raw and conditioned button bus between the push-buttons and the attendant call FSM.
// The conditioner is the slave: it samples btn_raw and drives the conditioned outputs.
interface attendant_button_conditioner_if;
   import attendant_button_conditioner_pkg::*;

   btn_t btn_raw;
   btn_t btn_out;
   btn_t btn_stable;

   modport master (output btn_raw, input btn_out, input btn_stable);
   modport slave  (input btn_raw, output btn_out, output btn_stable);

endinterface

// File: rtl/attendant_button_conditioner_debounce.sv
// Single-channel two-flop synchroniser plus debounce counter; accept fires on the edge stable flips.
// Stable follows the raw line DEBOUNCE_CYCLES+2 edges after a clean change; no backpressure.
module button_debounce
   import attendant_button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic accept
);

   localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   assign accept = (s2 != stable) && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (accept) begin
            stable <= s2;
            cnt    <= '0;
         end else if (s2 != stable) begin
            cnt <= cnt + 1'b1;
         end else begin
            // any bounce back to the stable value restarts the count
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/attendant_button_conditioner.sv
// Conditions the call/cancel buttons into press pulses (or levels) for the attendant call FSM.
// Pulse appears DEBOUNCE_CYCLES+2 edges after a clean press, call wins ties; no backpressure.
module attendant_button_conditioner
   import attendant_button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter bit PULSE_MODE      = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   attendant_button_conditioner_if.slave btn
);

   btn_t stable;
   btn_t accept;
   btn_t rise;
   btn_t pulse;

   for (genvar i = 0; i < BTN_W; i++) begin : g_ch
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .raw    (btn.btn_raw[i]),
         .stable (stable[i]),
         .accept (accept[i])
      );
   end

   // accepting while stable is still 0 means a press, never a release
   assign rise = accept & ~stable;

   always_ff @(posedge clk) begin
      if (reset) begin
         pulse <= '0;
      end else begin
         pulse[CALL_IDX]   <= rise[CALL_IDX];
         pulse[CANCEL_IDX] <= rise[CANCEL_IDX] & ~rise[CALL_IDX];
      end
   end

   assign btn.btn_stable = stable;
   assign btn.btn_out    = PULSE_MODE ? pulse : stable;

endmodule

// File: tb/tb_attendant_button_conditioner.sv
// Drives a pulse-mode and a level-mode conditioner in parallel from the same button lines
// and compares both against a sliding-window reference of the debounce rule.
module tb_attendant_button_conditioner;
   import attendant_button_conditioner_pkg::*;

   localparam int D    = 4;
   localparam int HMSK = 8191;

   logic clk = 1'b0;
   logic reset;

   attendant_button_conditioner_if bif ();
   attendant_button_conditioner_if bif_l ();

   attendant_button_conditioner #(.DEBOUNCE_CYCLES(D), .PULSE_MODE(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .btn   (bif)
   );

   attendant_button_conditioner #(.DEBOUNCE_CYCLES(D), .PULSE_MODE(1'b0)) dut_l (
      .clk   (clk),
      .reset (reset),
      .btn   (bif_l)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int         cyc = 0;
   logic [1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_pulse = '0;
   logic [1:0] s2h [0:HMSK];
   int         last_evt [2];

   task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
      end
   endtask

   // A channel flips once its s2 has differed from stable on each of the last D edges
   // since the previous flip or reset.
   task automatic model_edge(input logic rst, input logic [1:0] raw);
      logic [1:0] rise;
      logic [1:0] nstable;
      bit         ok;
      cyc++;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_pulse = '0;
         last_evt[0] = cyc; last_evt[1] = cyc;
      end else begin
         s2h[cyc & HMSK] = m_s2;
         rise    = '0;
         nstable = m_stable;
         for (int c = 0; c < 2; c++) begin
            if (cyc - last_evt[c] >= D) begin
               ok = 1'b1;
               for (int j = 0; j < D; j++)
                  if (s2h[(cyc - j) & HMSK][c] == m_stable[c]) ok = 1'b0;
               if (ok) begin
                  nstable[c]  = ~m_stable[c];
                  rise[c]     = ~m_stable[c];
                  last_evt[c] = cyc;
               end
            end
         end
         m_stable = nstable;
         m_pulse  = {rise[1], rise[0] & ~rise[1]};
         m_s2     = m_s1;
         m_s1     = raw;
      end
   endtask

   task automatic step(input logic rst, input logic [1:0] raw);
      reset       = rst;
      bif.btn_raw   = raw;
      bif_l.btn_raw = raw;
      @(posedge clk);
      #1;
      model_edge(rst, raw);
      check("out_pulse",  bif.btn_out,      m_pulse);
      check("stable",     bif.btn_stable,   m_stable);
      check("out_level",  bif_l.btn_out,    m_stable);
      check("stable_lvl", bif_l.btn_stable, m_stable);
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00);
   endtask

   initial begin
      reset = 1'b1;
      bif.btn_raw   = '0;
      bif_l.btn_raw = '0;
      last_evt[0] = 0;
      last_evt[1] = 0;

      // reset with both buttons held, then held through release
      step(1'b1, 2'b11);
      step(1'b1, 2'b11);
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 2'b11);
         check("rst_hold_out", bif.btn_out, (i == 6) ? 2'b10 : 2'b00);
      end
      check("rst_hold_stable", bif.btn_stable, 2'b11);
      settle(10);

      // clean call press
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 2'b10);
         check("call_out", bif.btn_out, (i == 6) ? 2'b10 : 2'b00);
      end
      settle(10);

      // bouncing cancel, then held
      step(1'b0, 2'b01); step(1'b0, 2'b00); step(1'b0, 2'b01); step(1'b0, 2'b00);
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 2'b01);
         check("bounce_out", bif.btn_out, (i == 6) ? 2'b01 : 2'b00);
      end
      settle(10);

      // three-cycle glitch on call
      for (int i = 0; i < 3; i++) step(1'b0, 2'b10);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 2'b00);
         check("glitch_out", bif.btn_out, 2'b00);
         check("glitch_stable", bif.btn_stable, 2'b00);
      end

      // simultaneous press: call wins, cancel pulse dropped
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 2'b11);
         check("simul_out", bif.btn_out, (i == 6) ? 2'b10 : 2'b00);
      end
      check("simul_stable", bif.btn_stable, 2'b11);
      check("simul_level", bif_l.btn_out, 2'b11);
      settle(10);

      // reset two edges into a call count, button held throughout
      step(1'b0, 2'b10); step(1'b0, 2'b10); step(1'b0, 2'b10);
      step(1'b1, 2'b10);
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 2'b10);
         check("midrst_out", bif.btn_out, (i == 6) ? 2'b10 : 2'b00);
         check("midrst_level", bif_l.btn_out, (i >= 6) ? 2'b10 : 2'b00);
      end
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 2'b00);
         check("release_level", bif_l.btn_out, (i >= 6) ? 2'b00 : 2'b10);
         check("release_pulse", bif.btn_out, 2'b00);
      end

      // randomized hold/bounce patterns with occasional resets
      for (int n = 0; n < 400; n++) begin
         int         hold;
         logic [1:0] raw;
         logic       rst;
         hold = $urandom_range(1, 9);
         raw  = 2'($urandom_range(0, 3));
         rst  = ($urandom_range(0, 40) == 0);
         for (int h = 0; h < hold; h++) step(rst && (h == 0), raw);
      end
      settle(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
